sram_bus_ctrl: RTL and testbench
================================

Name: sram_bus_ctrl

Overview:
Downstream memory-port stage for the SUBNEG core: accepts one read or write request at a time over a valid/ready handshake. It sequences the shared 8-bit address/data bus, the external address latch enable, and the active-low SRAM OE/WE strobes. Read data and write completion return as a one-cycle response pulse. The core issues abstract accesses and no longer toggles pins itself.

Parameters:
OE_WAIT, 1, extra cycles OE is held low before sampling read data (legal range 0..15)
WE_PULSE, 1, cycles WE is held low per write (legal range 1..15)

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
req_valid  in  1  request present
req_ready  out  1  controller idle, request may be accepted
req_we  in  1  1 = write, 0 = read
req_addr  in  8  SRAM address
req_wdata  in  8  write data
rsp_valid  out  1  one-cycle completion pulse, for both reads and writes
rsp_rdata  out  8  read data; valid while rsp_valid=1 after a read; holds last read value otherwise
latch_le  out  1  external address latch enable (1 = transparent)
mem_oe_n  out  1  SRAM output enable, active low
mem_we_n  out  1  SRAM write enable, active low
bus_out  out  8  value driven onto the shared bus
bus_oe  out  8  per-bit bus drive enable (1 = drive); always all-ones or all-zeros
bus_in  in  8  shared bus sampled value

Behaviour:
- All outputs registered. Reset (async, immediate) values:
  - latch_le=0, mem_oe_n=1, mem_we_n=1, bus_oe=8'h00, bus_out=8'h00.
  - req_ready=1, rsp_valid=0, rsp_rdata=8'h00, state=IDLE.
- Accept: at a rising edge with req_valid & req_ready (edge k). req_we, req_addr and req_wdata are captured. req_ready drops from k+1 until the FSM returns to IDLE.
- States and outputs per cycle:
  - IDLE: req_ready=1, all strobes inactive, bus_oe=00, latch_le=0.
  - ADDR (cycle k+1): bus_oe=FF, bus_out=addr, latch_le=1.
  - LATCH (k+2): latch_le=0, address still driven (hold).
  - Read path:
    - RD_OE (k+3): bus_oe=00, mem_oe_n=0.
    - RD_WAIT: OE_WAIT cycles, OE held low; skipped when OE_WAIT=0.
    - At edge k+4+OE_WAIT: rsp_rdata<=bus_in, rsp_valid<=1, state RD_END.
    - RD_END: mem_oe_n=1, bus_oe=00, rsp_valid=1, lasts one cycle, then IDLE.
  - Write path:
    - WR_SETUP (k+3): bus_out=wdata, bus_oe=FF, mem_we_n=1.
    - WR_PULSE (k+4 .. k+3+WE_PULSE): mem_we_n=0, data driven.
    - WR_HOLD (k+4+WE_PULSE): mem_we_n=1, data still driven, rsp_valid=1. Then IDLE.
- Latency, accept edge to the rsp_valid cycle:
  - Read: 4+OE_WAIT cycles (5 at defaults).
  - Write: 4+WE_PULSE cycles (5 at defaults).
  - Back-to-back requests: 6 cycles each at defaults.
- Invariants, checked by assertions:
  - Never bus_oe!=0 while mem_oe_n=0.
  - mem_oe_n and mem_we_n are never both 0.
  - latch_le=1 only in ADDR.
  - bus_out/bus_oe are stable throughout any mem_we_n=0 window.
- Wait counter: 4-bit, loaded at state entry, decremented each cycle.
- req_valid deasserting after accept has no effect. Requests arriving while req_ready=0 are ignored, not queued.
- rsp_valid and acceptance never coincide. IDLE is always at least one cycle, which gives a bus turnaround after reads.
- Reset mid-operation: the operation is abandoned with no response. Strobes return to their inactive reset values asynchronously. An aborted write may have partially written the SRAM; this is accepted.

Decomposition:
- Package sram_bus_pkg holds:
  - state enum (IDLE, ADDR, LATCH, RD_OE, RD_WAIT, RD_END, WR_SETUP, WR_PULSE, WR_HOLD);
  - ADDR_W=8, DATA_W=8;
  - STROBE_OFF constant bundle with the reset pin values.
- Single module. The wait counter is too small to justify a sub-module.

Test Plan:
- Reset: assert reset mid-cycle -> immediately latch_le=0, mem_oe_n=1, mem_we_n=1, bus_oe=00, req_ready=1.
- Read at defaults: addr=8'h3C, SRAM model returns 8'hA5 -> latch_le high exactly at k+1 with bus_out=3C; OE low at k+3..k+4; rsp_valid at k+5 with rsp_rdata=A5.
- Write at defaults: addr=8'h10, wdata=8'h7E -> mem_we_n=0 only at k+4, bus_out=7E at k+3..k+5, rsp_valid at k+5; a subsequent read of 10 returns 7E.
- Parameter sweep OE_WAIT=0 and 3, WE_PULSE=3 -> read rsp_valid at k+4 and k+7; WE low for exactly 3 cycles; invariants hold throughout.
- Back-to-back requests with req_valid held high (write FF->addr FF, then read FF) -> second accept 6 cycles after the first; no overlap of OE/WE; read returns FF.
- Reset during WR_PULSE -> mem_we_n=1 asynchronously, no rsp_valid; the next request after reset completes normally.

Source files
------------

// File: rtl/sram_bus_pkg.sv
// Shared types and constants for the SRAM bus controller.
//   state_t    : controller FSM states
//   pins_t     : bundle of the registered pin-side outputs
//   STROBE_OFF : pin values with every strobe inactive and the bus released
package sram_bus_pkg;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 8;

  typedef enum logic [3:0] {
    IDLE, ADDR, LATCH, RD_OE, RD_WAIT, RD_END, WR_SETUP, WR_PULSE, WR_HOLD
  } state_t;

  typedef struct packed {
    logic              latch_le;
    logic              mem_oe_n;
    logic              mem_we_n;
    logic [DATA_W-1:0] bus_oe;
    logic [DATA_W-1:0] bus_out;
  } pins_t;

  localparam pins_t STROBE_OFF = '{
    latch_le: 1'b0,
    mem_oe_n: 1'b1,
    mem_we_n: 1'b1,
    bus_oe:   '0,
    bus_out:  '0
  };

endpackage

// File: rtl/sram_bus_ctrl.sv
// Memory-port stage: turns one abstract read/write request at a time into
// the multiplexed address/data bus sequence for an external address latch
// plus an asynchronous SRAM with active-low OE/WE.
// Ports:
//   clk, reset                  clock, async active-high reset
//   req_valid/req_ready         request handshake (accept on valid & ready)
//   req_we/req_addr/req_wdata   request payload, captured at accept
//   rsp_valid/rsp_rdata         one-cycle completion pulse, last read data
//   latch_le                    external address latch enable
//   mem_oe_n/mem_we_n           SRAM strobes, active low
//   bus_out/bus_oe/bus_in       shared bus drive value, drive enable, sample
module sram_bus_ctrl
  import sram_bus_pkg::*;
#(
  parameter int OE_WAIT  = 1,  // 0..15
  parameter int WE_PULSE = 1   // 1..15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              latch_le,
  output logic              mem_oe_n,
  output logic              mem_we_n,
  output logic [DATA_W-1:0] bus_out,
  output logic [DATA_W-1:0] bus_oe,
  input  logic [DATA_W-1:0] bus_in
);

  localparam logic [3:0] OE_LD = 4'((OE_WAIT > 0) ? OE_WAIT - 1 : 0);
  localparam logic [3:0] WE_LD = 4'((WE_PULSE > 0) ? WE_PULSE - 1 : 0);

  state_t            state, next_state;
  logic [3:0]        cnt;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  pins_t             pins, pins_d;
  logic              rdy_d, rsp_d;
  logic              accept;

  // req_ready is 1 exactly while state == IDLE
  assign accept = req_valid & req_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:     if (req_valid) next_state = ADDR;
      ADDR:     next_state = LATCH;
      LATCH:    next_state = we_q ? WR_SETUP : RD_OE;
      RD_OE:    next_state = (OE_WAIT == 0) ? RD_END : RD_WAIT;
      RD_WAIT:  if (cnt == 4'd0) next_state = RD_END;
      RD_END:   next_state = IDLE;
      WR_SETUP: next_state = WR_PULSE;
      WR_PULSE: if (cnt == 4'd0) next_state = WR_HOLD;
      WR_HOLD:  next_state = IDLE;
      default:  next_state = IDLE;
    endcase
  end

  // Outputs are decoded from next_state and registered, so the pins change
  // on the same edge the state does and never glitch.
  always_comb begin
    pins_d = STROBE_OFF;
    rdy_d  = 1'b0;
    rsp_d  = 1'b0;
    case (next_state)
      IDLE: rdy_d = 1'b1;
      ADDR: begin
        // entered only from IDLE on accept, so the payload is still on req_*
        pins_d.latch_le = 1'b1;
        pins_d.bus_oe   = '1;
        pins_d.bus_out  = req_addr;
      end
      LATCH: begin
        pins_d.bus_oe  = '1;
        pins_d.bus_out = addr_q;
      end
      RD_OE, RD_WAIT: pins_d.mem_oe_n = 1'b0;
      RD_END:         rsp_d = 1'b1;
      WR_SETUP: begin
        pins_d.bus_oe  = '1;
        pins_d.bus_out = wdata_q;
      end
      WR_PULSE: begin
        pins_d.bus_oe   = '1;
        pins_d.bus_out  = wdata_q;
        pins_d.mem_we_n = 1'b0;
      end
      WR_HOLD: begin
        pins_d.bus_oe  = '1;
        pins_d.bus_out = wdata_q;
        rsp_d          = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pins      <= STROBE_OFF;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      cnt       <= 4'd0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
    end else begin
      pins      <= pins_d;
      req_ready <= rdy_d;
      rsp_valid <= rsp_d;
      if (accept) begin
        we_q    <= req_we;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
      end
      // sample while OE is still low, on the edge that leaves the OE window
      if (next_state == RD_END) rsp_rdata <= bus_in;
      // counter loads on entry to a timed state, then counts down
      if (next_state != state)
        cnt <= (next_state == WR_PULSE) ? WE_LD :
               (next_state == RD_WAIT)  ? OE_LD : 4'd0;
      else if (cnt != 4'd0)
        cnt <= cnt - 4'd1;
    end
  end

  assign latch_le = pins.latch_le;
  assign mem_oe_n = pins.mem_oe_n;
  assign mem_we_n = pins.mem_we_n;
  assign bus_oe   = pins.bus_oe;
  assign bus_out  = pins.bus_out;

  a_no_contention: assert property (@(posedge clk) disable iff (reset)
    !(!mem_oe_n && bus_oe != '0));
  a_strobe_excl: assert property (@(posedge clk) disable iff (reset)
    !(!mem_oe_n && !mem_we_n));
  a_latch_addr: assert property (@(posedge clk) disable iff (reset)
    latch_le |-> state == ADDR);
  a_we_stable: assert property (@(posedge clk) disable iff (reset)
    !mem_we_n |-> ($stable(bus_out) && $stable(bus_oe)));

endmodule

// File: tb/tb_sram_bus_ctrl.sv
// Directed bench for sram_bus_ctrl: a default-parameter instance wired to a
// latch + SRAM model, and two parameter-sweep instances on a fixed bus value.
module tb_sram_bus_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_valid, req_we, req_ready, rsp_valid;
  logic [7:0] req_addr, req_wdata, rsp_rdata;
  logic       latch_le, mem_oe_n, mem_we_n;
  logic [7:0] bus_out, bus_oe, bus_in;

  logic            sv, swe;
  logic [7:0]      saddr, swdata;
  logic [7:0]      sbus_in = 8'h5A;
  logic [1:0]      s_ready, s_rsp, s_le, s_oe_n, s_we_n;
  logic [1:0][7:0] s_rdata, s_bout, s_boe;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  sram_bus_ctrl u_dut (
    .clk(clk), .reset(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .latch_le(latch_le),
    .mem_oe_n(mem_oe_n), .mem_we_n(mem_we_n), .bus_out(bus_out),
    .bus_oe(bus_oe), .bus_in(bus_in));

  sram_bus_ctrl #(.OE_WAIT(0), .WE_PULSE(3)) u_s0 (
    .clk(clk), .reset(rst), .req_valid(sv), .req_ready(s_ready[0]),
    .req_we(swe), .req_addr(saddr), .req_wdata(swdata),
    .rsp_valid(s_rsp[0]), .rsp_rdata(s_rdata[0]), .latch_le(s_le[0]),
    .mem_oe_n(s_oe_n[0]), .mem_we_n(s_we_n[0]), .bus_out(s_bout[0]),
    .bus_oe(s_boe[0]), .bus_in(sbus_in));

  sram_bus_ctrl #(.OE_WAIT(3), .WE_PULSE(3)) u_s3 (
    .clk(clk), .reset(rst), .req_valid(sv), .req_ready(s_ready[1]),
    .req_we(swe), .req_addr(saddr), .req_wdata(swdata),
    .rsp_valid(s_rsp[1]), .rsp_rdata(s_rdata[1]), .latch_le(s_le[1]),
    .mem_oe_n(s_oe_n[1]), .mem_we_n(s_we_n[1]), .bus_out(s_bout[1]),
    .bus_oe(s_boe[1]), .bus_in(sbus_in));

  // external latch + SRAM model
  logic [7:0] mem [256];
  logic [7:0] laddr = 8'h00;
  always @(posedge clk) if (latch_le === 1'b1) laddr <= bus_out;
  always @(posedge clk) if (mem_we_n === 1'b0) mem[laddr] <= bus_out;
  assign bus_in = (mem_oe_n === 1'b0) ? mem[laddr] : 8'h00;

  task automatic do_read(input logic [7:0] a, output logic [7:0] d, output int lat);
    d = 8'h00; lat = -1;
    @(negedge clk); req_valid = 1'b1; req_we = 1'b0; req_addr = a;
    @(posedge clk);
    for (int j = 1; j <= 20; j++) begin
      @(negedge clk); req_valid = 1'b0;
      if (rsp_valid === 1'b1 && lat < 0) begin lat = j; d = rsp_rdata; end
      if (lat >= 0 && req_ready === 1'b1) break;
    end
  endtask

  task automatic test_reset();
    #3;
    n_chk++; if (latch_le !== 1'b0) begin n_fail++; $display("FAIL rst0 latch_le got %b want 0", latch_le); end
    n_chk++; if (mem_oe_n !== 1'b1) begin n_fail++; $display("FAIL rst0 mem_oe_n got %b want 1", mem_oe_n); end
    n_chk++; if (mem_we_n !== 1'b1) begin n_fail++; $display("FAIL rst0 mem_we_n got %b want 1", mem_we_n); end
    n_chk++; if (bus_oe !== 8'h00) begin n_fail++; $display("FAIL rst0 bus_oe got %h want 00", bus_oe); end
    n_chk++; if (bus_out !== 8'h00) begin n_fail++; $display("FAIL rst0 bus_out got %h want 00", bus_out); end
    n_chk++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL rst0 req_ready got %b want 1", req_ready); end
    n_chk++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rst0 rsp_valid got %b want 0", rsp_valid); end
    n_chk++; if (rsp_rdata !== 8'h00) begin n_fail++; $display("FAIL rst0 rsp_rdata got %h want 00", rsp_rdata); end
    @(negedge clk); rst = 1'b0;
    // start a read, then reset in the middle of its OE window
    @(negedge clk); req_valid = 1'b1; req_we = 1'b0; req_addr = 8'h3C;
    @(posedge clk);
    repeat (3) begin @(negedge clk); req_valid = 1'b0; end
    n_chk++; if (mem_oe_n !== 1'b0) begin n_fail++; $display("FAIL rst_mid pre oe_n got %b want 0", mem_oe_n); end
    #2 rst = 1'b1;
    #1;
    n_chk++; if (latch_le !== 1'b0) begin n_fail++; $display("FAIL rst_mid latch_le got %b want 0", latch_le); end
    n_chk++; if (mem_oe_n !== 1'b1) begin n_fail++; $display("FAIL rst_mid mem_oe_n got %b want 1", mem_oe_n); end
    n_chk++; if (mem_we_n !== 1'b1) begin n_fail++; $display("FAIL rst_mid mem_we_n got %b want 1", mem_we_n); end
    n_chk++; if (bus_oe !== 8'h00) begin n_fail++; $display("FAIL rst_mid bus_oe got %h want 00", bus_oe); end
    n_chk++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL rst_mid req_ready got %b want 1", req_ready); end
    @(negedge clk); rst = 1'b0;
    for (int j = 0; j < 4; j++) begin
      @(negedge clk);
      n_chk++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rst_mid rsp_valid c%0d got %b want 0", j, rsp_valid); end
    end
  endtask

  task automatic test_read();
    logic [6:0] e_le  = 7'b0000010;
    logic [6:0] e_oen = 7'b1100111;
    logic [6:0] e_rsp = 7'b0100000;
    logic [6:0] e_rdy = 7'b1000000;
    @(negedge clk); req_valid = 1'b1; req_we = 1'b0; req_addr = 8'h3C;
    n_chk++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL rd ready_pre got %b want 1", req_ready); end
    @(posedge clk);
    for (int j = 1; j <= 6; j++) begin
      @(negedge clk); req_valid = 1'b0;
      n_chk++; if (latch_le !== e_le[j]) begin n_fail++; $display("FAIL rd latch_le c%0d got %b want %b", j, latch_le, e_le[j]); end
      n_chk++; if (mem_oe_n !== e_oen[j]) begin n_fail++; $display("FAIL rd mem_oe_n c%0d got %b want %b", j, mem_oe_n, e_oen[j]); end
      n_chk++; if (rsp_valid !== e_rsp[j]) begin n_fail++; $display("FAIL rd rsp_valid c%0d got %b want %b", j, rsp_valid, e_rsp[j]); end
      n_chk++; if (req_ready !== e_rdy[j]) begin n_fail++; $display("FAIL rd req_ready c%0d got %b want %b", j, req_ready, e_rdy[j]); end
      n_chk++; if (mem_we_n !== 1'b1) begin n_fail++; $display("FAIL rd mem_we_n c%0d got %b want 1", j, mem_we_n); end
      if (j == 1) begin
        n_chk++; if (bus_out !== 8'h3C) begin n_fail++; $display("FAIL rd addr bus_out got %h want 3c", bus_out); end
        n_chk++; if (bus_oe !== 8'hFF) begin n_fail++; $display("FAIL rd addr bus_oe got %h want ff", bus_oe); end
      end
      if (j >= 3) begin
        n_chk++; if (bus_oe !== 8'h00) begin n_fail++; $display("FAIL rd bus_oe c%0d got %h want 00", j, bus_oe); end
      end
      if (j == 5) begin
        n_chk++; if (rsp_rdata !== 8'hA5) begin n_fail++; $display("FAIL rd rdata got %h want a5", rsp_rdata); end
      end
    end
  endtask

  task automatic test_write();
    logic [6:0] e_wen = 7'b1101111;
    logic [6:0] e_rsp = 7'b0100000;
    logic [6:0] e_rdy = 7'b1000000;
    logic [7:0] d;
    int lat;
    @(negedge clk); req_valid = 1'b1; req_we = 1'b1; req_addr = 8'h10; req_wdata = 8'h7E;
    @(posedge clk);
    for (int j = 1; j <= 6; j++) begin
      @(negedge clk); req_valid = 1'b0;
      n_chk++; if (mem_we_n !== e_wen[j]) begin n_fail++; $display("FAIL wr mem_we_n c%0d got %b want %b", j, mem_we_n, e_wen[j]); end
      n_chk++; if (rsp_valid !== e_rsp[j]) begin n_fail++; $display("FAIL wr rsp_valid c%0d got %b want %b", j, rsp_valid, e_rsp[j]); end
      n_chk++; if (req_ready !== e_rdy[j]) begin n_fail++; $display("FAIL wr req_ready c%0d got %b want %b", j, req_ready, e_rdy[j]); end
      n_chk++; if (mem_oe_n !== 1'b1) begin n_fail++; $display("FAIL wr mem_oe_n c%0d got %b want 1", j, mem_oe_n); end
      if (j <= 2) begin
        n_chk++; if (bus_out !== 8'h10) begin n_fail++; $display("FAIL wr addr c%0d got %h want 10", j, bus_out); end
      end else if (j <= 5) begin
        n_chk++; if (bus_out !== 8'h7E) begin n_fail++; $display("FAIL wr data c%0d got %h want 7e", j, bus_out); end
        n_chk++; if (bus_oe !== 8'hFF) begin n_fail++; $display("FAIL wr bus_oe c%0d got %h want ff", j, bus_oe); end
      end else begin
        n_chk++; if (bus_oe !== 8'h00) begin n_fail++; $display("FAIL wr idle bus_oe got %h want 00", bus_oe); end
      end
    end
    do_read(8'h10, d, lat);
    n_chk++; if (lat !== 5) begin n_fail++; $display("FAIL wr readback latency got %0d want 5", lat); end
    n_chk++; if (d !== 8'h7E) begin n_fail++; $display("FAIL wr readback data got %h want 7e", d); end
  endtask

  task automatic test_sweep();
    int first[2], oe_cnt[2], we_cnt[2];
    int e_rd[2] = '{4, 7};
    int e_oe[2] = '{1, 4};
    // read on both sweep instances
    first = '{-1, -1}; oe_cnt = '{0, 0};
    @(negedge clk); sv = 1'b1; swe = 1'b0; saddr = 8'h44; swdata = 8'h00;
    @(posedge clk);
    for (int j = 1; j <= 12; j++) begin
      @(negedge clk); sv = 1'b0;
      for (int i = 0; i < 2; i++) begin
        if (s_oe_n[i] === 1'b0) oe_cnt[i]++;
        if (s_rsp[i] === 1'b1 && first[i] < 0) begin
          first[i] = j;
          n_chk++; if (s_rdata[i] !== 8'h5A) begin n_fail++; $display("FAIL sweep%0d rdata got %h want 5a", i, s_rdata[i]); end
        end
        n_chk++; if (s_oe_n[i] === 1'b0 && s_boe[i] !== 8'h00) begin n_fail++; $display("FAIL sweep%0d contention c%0d bus_oe %h want 00", i, j, s_boe[i]); end
      end
    end
    for (int i = 0; i < 2; i++) begin
      n_chk++; if (first[i] !== e_rd[i]) begin n_fail++; $display("FAIL sweep%0d rd latency got %0d want %0d", i, first[i], e_rd[i]); end
      n_chk++; if (oe_cnt[i] !== e_oe[i]) begin n_fail++; $display("FAIL sweep%0d oe cycles got %0d want %0d", i, oe_cnt[i], e_oe[i]); end
    end
    // write on both: WE low exactly 3 cycles, response at 4+3
    first = '{-1, -1}; we_cnt = '{0, 0};
    @(negedge clk); sv = 1'b1; swe = 1'b1; saddr = 8'h45; swdata = 8'hC3;
    @(posedge clk);
    for (int j = 1; j <= 10; j++) begin
      @(negedge clk); sv = 1'b0;
      for (int i = 0; i < 2; i++) begin
        if (s_we_n[i] === 1'b0) begin
          we_cnt[i]++;
          n_chk++; if (s_bout[i] !== 8'hC3) begin n_fail++; $display("FAIL sweep%0d we data c%0d got %h want c3", i, j, s_bout[i]); end
        end
        if (s_rsp[i] === 1'b1 && first[i] < 0) first[i] = j;
        n_chk++; if (s_oe_n[i] === 1'b0 && s_we_n[i] === 1'b0) begin n_fail++; $display("FAIL sweep%0d oe/we overlap c%0d got 00 want not both low", i, j); end
      end
    end
    for (int i = 0; i < 2; i++) begin
      n_chk++; if (we_cnt[i] !== 3) begin n_fail++; $display("FAIL sweep%0d we cycles got %0d want 3", i, we_cnt[i]); end
      n_chk++; if (first[i] !== 7) begin n_fail++; $display("FAIL sweep%0d wr latency got %0d want 7", i, first[i]); end
    end
  endtask

  task automatic test_back_to_back();
    int gap = -1;
    int lat = -1;
    logic [7:0] d = 8'h00;
    @(negedge clk); req_valid = 1'b1; req_we = 1'b1; req_addr = 8'hFF; req_wdata = 8'hFF;
    @(posedge clk);
    @(negedge clk); req_we = 1'b0;  // next request is the read, valid stays high
    for (int j = 1; j <= 12; j++) begin
      n_chk++; if (mem_oe_n === 1'b0 && mem_we_n === 1'b0) begin n_fail++; $display("FAIL b2b overlap c%0d got both low want not", j); end
      if (req_ready === 1'b1) begin gap = j; break; end
      @(negedge clk);
    end
    n_chk++; if (gap !== 6) begin n_fail++; $display("FAIL b2b accept spacing got %0d want 6", gap); end
    @(posedge clk);
    for (int j = 1; j <= 12; j++) begin
      @(negedge clk); req_valid = 1'b0;
      n_chk++; if (mem_oe_n === 1'b0 && mem_we_n === 1'b0) begin n_fail++; $display("FAIL b2b overlap rd c%0d got both low want not", j); end
      if (rsp_valid === 1'b1 && lat < 0) begin lat = j; d = rsp_rdata; end
      if (lat >= 0 && req_ready === 1'b1) break;
    end
    n_chk++; if (lat !== 5) begin n_fail++; $display("FAIL b2b rd latency got %0d want 5", lat); end
    n_chk++; if (d !== 8'hFF) begin n_fail++; $display("FAIL b2b rd data got %h want ff", d); end
  endtask

  task automatic test_reset_write();
    logic [7:0] d;
    int lat;
    @(negedge clk); req_valid = 1'b1; req_we = 1'b1; req_addr = 8'h20; req_wdata = 8'h55;
    @(posedge clk);
    repeat (4) begin @(negedge clk); req_valid = 1'b0; end
    n_chk++; if (mem_we_n !== 1'b0) begin n_fail++; $display("FAIL rstwr pre we_n got %b want 0", mem_we_n); end
    #2 rst = 1'b1;
    #1;
    n_chk++; if (mem_we_n !== 1'b1) begin n_fail++; $display("FAIL rstwr mem_we_n got %b want 1", mem_we_n); end
    n_chk++; if (bus_oe !== 8'h00) begin n_fail++; $display("FAIL rstwr bus_oe got %h want 00", bus_oe); end
    n_chk++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rstwr rsp_valid got %b want 0", rsp_valid); end
    @(negedge clk); rst = 1'b0;
    for (int j = 0; j < 4; j++) begin
      @(negedge clk);
      n_chk++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rstwr late rsp c%0d got %b want 0", j, rsp_valid); end
    end
    do_read(8'h3C, d, lat);
    n_chk++; if (lat !== 5) begin n_fail++; $display("FAIL rstwr next latency got %0d want 5", lat); end
    n_chk++; if (d !== 8'hA5) begin n_fail++; $display("FAIL rstwr next data got %h want a5", d); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[8'h3C] = 8'hA5;
    rst = 1'b1;
    req_valid = 1'b0; req_we = 1'b0; req_addr = 8'h00; req_wdata = 8'h00;
    sv = 1'b0; swe = 1'b0; saddr = 8'h00; swdata = 8'h00;
    test_reset();
    test_read();
    test_write();
    test_sweep();
    test_back_to_back();
    test_reset_write();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
